// File: rtl/ram_bus_bridge.sv
// Bridge from the ARMv4 core memory port to a cs/oe/we/ready RAM handshake.
// Build option: define RAM_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles without ram_ready.
module ram_bus_bridge #(
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        ram_cs,
  output logic        ram_oe,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] SETUP_LAST = 2'(SETUP_CYC - 1);

  logic [1:0]  state;
  logic [1:0]  setup_cnt;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        timeout_hit;

  logic        req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] rd_ext;

  assign busy = (state != IDLE);

  // Reserved size 2'b11 behaves exactly like a word access.
  always_comb begin
    req_misaligned = 1'b0;
    req_be         = 4'b1111;
    req_wdata      = wdata;
    case (size)
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned = addr[0];
        req_be         = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata      = {2{wdata[15:0]}};
      end
      default: begin
        req_misaligned = |addr[1:0];
      end
    endcase
  end

  always_comb begin
    rd_ext = ram_rdata;
    case (size_q)
      2'b00:   rd_ext = {24'b0, ram_rdata[{lane_q, 3'b000} +: 8]};
      2'b01:   rd_ext = lane_q[1] ? {16'b0, ram_rdata[31:16]} : {16'b0, ram_rdata[15:0]};
      default: rd_ext = ram_rdata;
    endcase
  end

`ifdef RAM_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_CYC - 1);
  logic [3:0] wait_cnt;

  // Counts cycles spent in WAIT; zero whenever outside WAIT so each entry starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
    else                    wait_cnt <= '0;
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      setup_cnt <= '0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      ram_cs    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_be    <= '0;
      ram_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wr_q   <= wr;
            size_q <= size;
            lane_q <= addr[1:0];
            if (req_misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              ram_cs    <= 1'b1;
              ram_addr  <= {addr[31:2], 2'b00};
              ram_be    <= req_be;
              ram_wdata <= req_wdata;
              if (SETUP_CYC == 0) begin
                state  <= WAIT;
                ram_oe <= ~wr;
                ram_we <= wr;
              end else begin
                state     <= SETUP;
                setup_cnt <= '0;
              end
            end
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            state  <= WAIT;
            ram_oe <= ~wr_q;
            ram_we <= wr_q;
          end else begin
            setup_cnt <= setup_cnt + 2'd1;
          end
        end
        WAIT: begin
          // A ready arriving on the expiry cycle still counts as a normal completion.
          if (ram_ready || timeout_hit) begin
            state     <= DONE;
            done      <= 1'b1;
            err       <= ~ram_ready;
            ram_cs    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_be    <= '0;
            ram_wdata <= '0;
            if (ram_ready && !wr_q) rdata <= rd_ext;
          end
        end
        default: begin
          state <= IDLE;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Directed self-checking bench for ram_bus_bridge (default SETUP_CYC=1, TIMEOUT_CYC=15).
module tb_ram_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size = '0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        ram_cs;
  logic        ram_oe;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;

  int compare_count = 0;
  int fail_count = 0;

  ram_bus_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .ram_cs    (ram_cs),
    .ram_oe    (ram_oe),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_be    (ram_be),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ready (ram_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s);
    req   = r;
    wr    = w;
    addr  = a;
    wdata = d;
    size  = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    $display("[TB] start");
    #3;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_cs_oe_we", {29'd0, ram_cs, ram_oe, ram_we}, 32'd0);
    checkOutput("reset_addr", ram_addr, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: word read at 0x100, ready raised after two WAIT cycles
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("t1_setup_cs_oe_we", {29'd0, ram_cs, ram_oe, ram_we}, 32'b100);
    checkOutput("t1_setup_addr", ram_addr, 32'h100);
    checkOutput("t1_setup_be", 32'(ram_be), 32'hF);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("t1_wait_cs_oe_we", {29'd0, ram_cs, ram_oe, ram_we}, 32'b110);
    tick();
    checkOutput("t1_wait2_done", 32'(done), 32'd0);
    ram_ready = 1'b1;
    ram_rdata = 32'hDEADBEEF;
    tick();
    ram_ready = 1'b0;
    checkOutput("t1_done_err", {30'd0, done, err}, 32'b10);
    checkOutput("t1_rdata", rdata, 32'hDEADBEEF);
    checkOutput("t1_done_cs_oe_we", {29'd0, ram_cs, ram_oe, ram_we}, 32'd0);
    tick();
    checkOutput("t1_idle_done_busy", {30'd0, done, busy}, 32'd0);

    // 2: byte write at 0x203, ready in first WAIT cycle
    applyStimulus(1'b1, 1'b1, 32'h203, 32'hA5, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("t2_be", 32'(ram_be), 32'b1000);
    checkOutput("t2_wdata", ram_wdata, 32'hA5A5A5A5);
    checkOutput("t2_addr", ram_addr, 32'h200);
    checkOutput("t2_setup_we", 32'(ram_we), 32'd0);
    tick();
    checkOutput("t2_wait_cs_oe_we", {29'd0, ram_cs, ram_oe, ram_we}, 32'b101);
    ram_ready = 1'b1;
    ram_rdata = 32'h55555555;
    tick();
    ram_ready = 1'b0;
    checkOutput("t2_done_err", {30'd0, done, err}, 32'b10);
    checkOutput("t2_rdata_kept", rdata, 32'hDEADBEEF);
    tick();

    // 3: half reads at 0x12 and 0x10; ready is already high during SETUP and must be ignored there
    ram_rdata = 32'h12345678;
    applyStimulus(1'b1, 1'b0, 32'h12, 32'h0, 2'b01);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("t3a_be", 32'(ram_be), 32'b1100);
    checkOutput("t3a_addr", ram_addr, 32'h10);
    ram_ready = 1'b1;
    tick();
    checkOutput("t3a_wait_not_done", {30'd0, done, ram_oe}, 32'b01);
    tick();
    ram_ready = 1'b0;
    checkOutput("t3a_rdata", rdata, 32'h00001234);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 2'b01);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("t3b_be", 32'(ram_be), 32'b0011);
    tick();
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    checkOutput("t3b_rdata", rdata, 32'h00005678);
    tick();

    // byte read from lane 1 of 0x12345678
    applyStimulus(1'b1, 1'b0, 32'h301, 32'h0, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("t3c_be", 32'(ram_be), 32'b0010);
    tick();
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    checkOutput("t3c_rdata", rdata, 32'h00000056);
    tick();

    // 4: misaligned word at 0x101
    applyStimulus(1'b1, 1'b0, 32'h101, 32'h0, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("t4_done_err", {30'd0, done, err}, 32'b11);
    checkOutput("t4_cs", 32'(ram_cs), 32'd0);
    checkOutput("t4_rdata_kept", rdata, 32'h00000056);
    tick();
    checkOutput("t4_after_done_err_busy", {29'd0, done, err, busy}, 32'd0);

    // 5: reset asserted while in WAIT, then a fresh read
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    checkOutput("t5_in_wait_oe", 32'(ram_oe), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_cs_oe_we", {29'd0, ram_cs, ram_oe, ram_we}, 32'd0);
    checkOutput("t5_rst_addr", ram_addr, 32'd0);
    checkOutput("t5_rst_be_busy", {27'd0, ram_be, busy}, 32'd0);
    checkOutput("t5_rst_rdata", rdata, 32'd0);
    tick();
    checkOutput("t5_rst_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    ram_rdata = 32'hCAFEF00D;
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    checkOutput("t5_new_addr", ram_addr, 32'h44);
    tick();
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    checkOutput("t5_new_done_err", {30'd0, done, err}, 32'b10);
    checkOutput("t5_new_rdata", rdata, 32'hCAFEF00D);
    tick();

`ifdef RAM_TIMEOUT_EN
    // 6: timeout after 15 WAIT cycles, then ready on the expiry cycle
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    for (int i = 0; i < 14; i++) tick();
    checkOutput("t6_before_expiry", {30'd0, done, busy}, 32'b01);
    tick();
    checkOutput("t6_timeout_done_err", {30'd0, done, err}, 32'b11);
    checkOutput("t6_timeout_cs", 32'(ram_cs), 32'd0);
    checkOutput("t6_rdata_kept", rdata, 32'hCAFEF00D);
    tick();
    ram_rdata = 32'h11112222;
    applyStimulus(1'b1, 1'b0, 32'h84, 32'h0, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    for (int i = 0; i < 14; i++) tick();
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    checkOutput("t6_race_done_err", {30'd0, done, err}, 32'b10);
    checkOutput("t6_race_rdata", rdata, 32'h11112222);
    tick();
`else
    // 6: without the timeout option WAIT persists until ready
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    for (int i = 0; i < 20; i++) tick();
    checkOutput("t6_still_waiting", {29'd0, done, busy, ram_oe}, 32'b011);
    ram_rdata = 32'h11112222;
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    checkOutput("t6_late_done_err", {30'd0, done, err}, 32'b10);
    checkOutput("t6_late_rdata", rdata, 32'h11112222);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
